// File: rtl/palette_bank_memory_pkg.sv
// Shared definitions for the palette RAM: default geometry, sequencer states
// and the native colour type.
package palette_pkg;

  localparam int DEF_NUM_PALETTES       = 16;
  localparam int DEF_COLORS_PER_PALETTE = 16;
  localparam int DEF_COLOR_W            = 24;
  localparam int DEF_BUS_W              = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clear_state_t;

  typedef logic [23:0] rgb_t;

endpackage

// File: rtl/palette_bank.sv
// One colour storage array: a single write port and NCH independent
// registered read ports (read-before-write on a same-entry collision).
module palette_bank
  import palette_pkg::*;
#(
  parameter  int ENTRIES = DEF_NUM_PALETTES * DEF_COLORS_PER_PALETTE,
  parameter  int COLOR_W = DEF_COLOR_W,
  parameter  int NCH     = 2,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [COLOR_W-1:0]     wdata,
  input  logic [NCH*AW-1:0]      raddr,
  output logic [NCH*COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [ENTRIES];

  // stage p0: storage update and per-channel read registers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    for (int c = 0; c < NCH; c++) begin
      rdata[c*COLOR_W +: COLOR_W] <= mem[raddr[c*AW +: AW]];
    end
  end

endmodule

// File: rtl/palette_bank_memory.sv
// Multi-channel palette RAM with two-beat CPU writes and a post-reset clear
// sweep. Define PALETTE_DOUBLE_BUFFER_EN for a swappable front/back bank pair.
module palette_bank_memory
  import palette_pkg::*;
#(
  parameter  int NUM_PALETTES       = DEF_NUM_PALETTES,
  parameter  int COLORS_PER_PALETTE = DEF_COLORS_PER_PALETTE,
  parameter  int COLOR_W            = DEF_COLOR_W,
  parameter  int BUS_W              = DEF_BUS_W,
  parameter  int NCH                = 2,
  localparam int ENTRIES            = NUM_PALETTES * COLORS_PER_PALETTE,
  localparam int AW                 = $clog2(ENTRIES),
  localparam int CW                 = $clog2(COLORS_PER_PALETTE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_enable,
  input  logic [AW:0]            write_addr,
  input  logic [BUS_W-1:0]       write_data,
  input  logic [NCH*AW-1:0]      read_addr,
  output logic [NCH*COLOR_W-1:0] read_data,
  output logic [NCH-1:0]         read_transparent,
  output logic                   busy,
  input  logic                   swap,
  output logic                   front_bank
);

  clear_state_t              state, state_nxt;
  logic [AW-1:0]             cnt, cnt_nxt;
  logic                      clearing, run;
  logic                      beat_lo, beat_hi;
  logic [BUS_W-1:0]          hold;
  logic [AW-1:0]             bank_waddr;
  logic [COLOR_W-1:0]        bank_wdata;
  logic                      vld_p0;
  logic [NCH-1:0]            trans_p0;
  logic [NCH*COLOR_W-1:0]    rd_p0;

  // High beat supplies the upper colour bits, hold supplies the low 16.
  function automatic logic [COLOR_W-1:0] join_color(input logic [BUS_W-1:0] hi,
                                                    input logic [BUS_W-1:0] lo);
    return {hi[COLOR_W-17:0], lo[15:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == AW'(ENTRIES - 1)) state_nxt = RUN;
    end
  end

  always_comb begin
    clearing = (state == CLEAR);
    run      = (state == RUN);
    busy     = clearing;
  end

  assign beat_lo    = run & write_enable & ~write_addr[0];
  assign beat_hi    = run & write_enable &  write_addr[0];
  assign bank_waddr = clearing ? cnt : write_addr[AW:1];
  assign bank_wdata = clearing ? '0 : join_color(write_data, hold);

  always_ff @(posedge clk) begin
    if (rst)          hold <= '0;
    else if (beat_lo) hold <= write_data;
  end

  // stage p0: read valid and transparency registered alongside bank data
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= run;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      trans_p0[c] <= (read_addr[c*AW +: CW] == '0);
    end
  end

`ifdef PALETTE_DOUBLE_BUFFER_EN
  logic                   front, sel_p0;
  logic [NCH*COLOR_W-1:0] rd0_p0, rd1_p0;

  always_ff @(posedge clk) begin
    if (rst)              front <= 1'b0;
    else if (run && swap) front <= ~front;
  end

  always_ff @(posedge clk) sel_p0 <= front;

  // Writes land in the back bank; the sweep clears both.
  palette_bank #(.ENTRIES(ENTRIES), .COLOR_W(COLOR_W), .NCH(NCH)) u_bank0 (
    .clk  (clk),
    .we   (clearing | (beat_hi & front)),
    .waddr(bank_waddr),
    .wdata(bank_wdata),
    .raddr(read_addr),
    .rdata(rd0_p0)
  );

  palette_bank #(.ENTRIES(ENTRIES), .COLOR_W(COLOR_W), .NCH(NCH)) u_bank1 (
    .clk  (clk),
    .we   (clearing | (beat_hi & ~front)),
    .waddr(bank_waddr),
    .wdata(bank_wdata),
    .raddr(read_addr),
    .rdata(rd1_p0)
  );

  assign rd_p0      = sel_p0 ? rd1_p0 : rd0_p0;
  assign front_bank = front;
`else
  logic unused_swap;

  palette_bank #(.ENTRIES(ENTRIES), .COLOR_W(COLOR_W), .NCH(NCH)) u_bank0 (
    .clk  (clk),
    .we   (clearing | beat_hi),
    .waddr(bank_waddr),
    .wdata(bank_wdata),
    .raddr(read_addr),
    .rdata(rd_p0)
  );

  assign unused_swap = swap;
  assign front_bank  = 1'b0;
`endif

  assign read_data        = vld_p0 ? rd_p0 : '0;
  assign read_transparent = vld_p0 ? trans_p0 : '0;

endmodule

// File: tb/tb_palette_bank_memory.sv
// Directed bench for palette_bank_memory: clear sweep timing, two-beat writes,
// multi-channel reads, and bank swap when PALETTE_DOUBLE_BUFFER_EN is defined.
module tb_palette_bank_memory;

  localparam int NCH     = 2;
  localparam int AW      = 8;
  localparam int COLOR_W = 24;
  localparam int BUS_W   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   write_enable;
  logic [AW:0]            write_addr;
  logic [BUS_W-1:0]       write_data;
  logic [NCH*AW-1:0]      read_addr;
  logic [NCH*COLOR_W-1:0] read_data;
  logic [NCH-1:0]         read_transparent;
  logic                   busy;
  logic                   swap;
  logic                   front_bank;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  palette_bank_memory dut (
    .clk             (clk),
    .rst             (rst),
    .write_enable    (write_enable),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .read_addr       (read_addr),
    .read_data       (read_data),
    .read_transparent(read_transparent),
    .busy            (busy),
    .swap            (swap),
    .front_bank      (front_bank)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int entry, input logic half, input logic [15:0] d);
    write_enable = 1'b1;
    write_addr   = {entry[AW-1:0], half};
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd0(input int entry, input logic [23:0] exp, input string tag);
    read_addr[AW-1:0] = entry[AW-1:0];
    tick();
    chk(tag, read_data[23:0], exp);
  endtask

  initial begin
    rst = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
    read_addr = '0; swap = 1'b0;

    // Reset for two cycles, then the first sweep with writes at cycle 10.
    tick(); tick();
    chk("busy_rst",  busy, 1'b1);
    chk("rdata_rst", read_data, '0);
    chk("trans_rst", read_transparent, '0);
    chk("front_rst", front_bank, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 1) chk("busy_first", busy, 1'b1);
      if (k == 9) begin
        write_enable = 1'b1; write_addr = {8'd3, 1'b0}; write_data = 16'hBEEF;
      end
      if (k == 10) begin
        write_addr = {8'd3, 1'b1}; write_data = 16'h00CD;
      end
      if (k == 11) write_enable = 1'b0;
      if (k == 255) chk("busy_255", busy, 1'b1);
      if (k == 256) chk("busy_256", busy, 1'b0);
    end
    rd0(0,   24'h0, "clr_e0");
    rd0(17,  24'h0, "clr_e17");
    rd0(255, 24'h0, "clr_e255");
    rd0(3,   24'h0, "drop_e3");

`ifndef PALETTE_DOUBLE_BUFFER_EN
    // hold must still be 0: the low beat during the sweep was dropped
    beat(21, 1'b1, 16'h0099);
    rd0(21, 24'h990000, "hold_drop");

    beat(1, 1'b0, 16'h5678);
    beat(1, 1'b1, 16'h0034);
    rd0(1, 24'h345678, "two_beat");

    beat(2, 1'b1, 16'h00AB);
    rd0(2, 24'hAB5678, "orphan");

    beat(1, 1'b0, 16'h1111);
    write_enable = 1'b1; write_addr = {8'd1, 1'b1}; write_data = 16'h0022;
    read_addr[AW-1:0] = 8'd1;
    tick();
    write_enable = 1'b0;
    chk("rdw_old", read_data[23:0], 24'h345678);
    tick();
    chk("rdw_new", read_data[23:0], 24'h221111);

    beat(16, 1'b0, 16'h1111); beat(16, 1'b1, 16'h0011);
    beat(17, 1'b0, 16'h2222); beat(17, 1'b1, 16'h0022);
    read_addr = {8'h11, 8'h10};
    tick();
    chk("dual_data",  read_data, 48'h222222111111);
    chk("dual_trans", read_transparent, 2'b01);

    read_addr = {8'h01, 8'h01};
    tick();
    chk("same_addr", read_data, 48'h221111221111);
    chk("same_trans", read_transparent, 2'b00);
`else
    beat(5, 1'b0, 16'h0000);
    beat(5, 1'b1, 16'h00FF);
    rd0(5, 24'h0, "db_before");
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("db_front", front_bank, 1'b1);
    rd0(5, 24'hFF0000, "db_after");
`endif

    // Second sweep: reads forced to 0, writes and swap ignored, reset at cycle 100.
    read_addr = {8'h00, 8'h10};
    rst = 1'b1;
    tick();
    chk("busy_rst2", busy, 1'b1);
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 1) begin
        chk("clr_rdata", read_data[23:0], 24'h0);
        chk("clr_trans", read_transparent[0], 1'b0);
      end
      if (k == 9) begin
        write_enable = 1'b1; write_addr = {8'd3, 1'b0}; write_data = 16'h7777;
      end
      if (k == 10) begin
        write_addr = {8'd3, 1'b1}; write_data = 16'h0077;
      end
      if (k == 11) write_enable = 1'b0;
      if (k == 20) swap = 1'b1;
      if (k == 21) begin
        swap = 1'b0;
        chk("swap_in_clear", front_bank, 1'b0);
      end
      if (k == 99) rst = 1'b1;
    end
    rst = 1'b0;
    chk("busy_mid_rst", busy, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) chk("busy2_255", busy, 1'b1);
      if (k == 256) chk("busy2_256", busy, 1'b0);
    end
    rd0(3,  24'h0, "drop_mid");
    rd0(16, 24'h0, "clr2_e16");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/palette_bank_memory.md
# palette_bank_memory

Parametrised, multi-channel colour palette RAM for the MadNES video path. The CPU side writes 24-bit colours as two 16-bit bus beats. Up to NCH pixel-pipeline channels (background, sprites, …) each look up one colour per cycle with fixed one-cycle latency. After reset, a built-in sequencer clears all entries, and an optional double-buffer mode lets software rewrite palettes mid-frame without visible tearing.

## Interface
- NUM_PALETTES, 16, palettes held
- COLORS_PER_PALETTE, 16, colours per palette (power of two)
- COLOR_W, 24, colour width in bits; must satisfy 17..32
- BUS_W, 16, CPU write-bus width
- NCH, 2, independent read channels
- Derived: ENTRIES = NUM_PALETTES*COLORS_PER_PALETTE; AW = $clog2(ENTRIES); CW = $clog2(COLORS_PER_PALETTE)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- write_enable  in  1  write strobe, one beat per cycle
- write_addr  in  AW+1  {entry, half}; half=0 low beat, half=1 high beat
- write_data  in  BUS_W  beat payload
- read_addr  in  NCH*AW  packed per-channel entry address, {palette, colour}
- read_data  out  NCH*COLOR_W  packed per-channel colour, registered
- read_transparent  out  NCH  registered; 1 when the channel's colour index (low CW bits) was 0
- busy  out  1  clear sweep in progress
- swap  in  1  bank-swap pulse (used only with PALETTE_DOUBLE_BUFFER_EN)
- front_bank  out  1  bank currently read (0 when the feature is compiled out)

## Operation
- Write assembler:
  - half=0 beat loads the holding register `hold` with write_data. Nothing is committed.
  - half=1 beat commits {write_data[COLOR_W-16-1:0], hold[15:0]} to `entry`.
  - Upper unused bits of the high beat are ignored.
  - A high beat always uses the current `hold`, even if it was loaded for another entry or never loaded (reset value 0).
  - `hold` is unchanged by a commit.
- Clear sequencer, states CLEAR and RUN:
  - rst forces CLEAR with counter=0.
  - CLEAR writes 0 to entry `counter` in every bank, increments the counter, and moves to RUN after entry ENTRIES-1.
  - CLEAR lasts exactly ENTRIES cycles after rst deasserts.
  - While in CLEAR: busy=1; write beats are dropped, including hold loads; read_data=0; read_transparent=0.
  - Reset asserted mid-sweep restarts the sweep at entry 0.
- Read channels:
  - Each channel registers mem[read_addr] and the transparency flag.
  - Channels are fully independent; identical addresses on several channels are legal.
- Reset values: read_data=0, read_transparent=0, busy=1, front_bank=0, hold=0.

## Timing
- Read latency is 1 cycle: an address applied at edge N produces data valid after edge N+1.
- Read during commit to the same entry in the same cycle returns the old value. The new value is visible to a read issued on the next cycle.
- Write throughput: one committed colour per 2 beats; beats may be back-to-back.
- busy falls on the cycle the first RUN-state write is accepted: ENTRIES cycles after rst deasserts.
- swap (when compiled in):
  - Toggles front_bank at the next edge.
  - A commit in the same cycle as swap lands in the pre-swap back bank.
  - Reads issued in the cycle after swap use the new front bank.
  - swap during CLEAR is ignored.

## Configuration
- PALETTE_DOUBLE_BUFFER_EN defined:
  - Two banks of ENTRIES colours.
  - Writes target bank !front_bank; reads target front_bank.
  - swap is active.
- PALETTE_DOUBLE_BUFFER_EN undefined:
  - Single bank; writes and reads target the same storage.
  - swap is ignored; front_bank is tied to 0.

## Structure
- Shared package palette_pkg holds:
  - default parameter constants (NUM_PALETTES, COLORS_PER_PALETTE, COLOR_W, BUS_W)
  - typedef enum clear_state_t {CLEAR, RUN}
  - typedef for the 24-bit colour (logic [23:0] rgb_t)
- Sub-module palette_bank: one ENTRIES×COLOR_W storage array with one write port and NCH registered read ports. It is instantiated once, or twice when double buffering is compiled in. The top level holds the assembler, sequencer and bank select.

## Test plan
- Reset clear:
  - Stimulus: hold rst 2 cycles, then release; pre-load garbage is irrelevant.
  - Required: busy=1 for exactly 256 cycles after release. Reading entries 0, 17 and 255 afterwards returns 0.
- Two-beat write:
  - Stimulus: beat (entry 1, half 0, 16'h5678), then (entry 1, half 1, 16'h0034).
  - Required: channel 0 read of entry 1 returns 24'h345678 one cycle after the address.
- Orphan high beat:
  - Stimulus: after the previous test, write (entry 2, half 1, 16'h00AB).
  - Required: entry 2 reads 24'hAB5678.
- Multi-channel and transparency:
  - Stimulus: ch0 addr 8'h10, ch1 addr 8'h11 in the same cycle, with entries preloaded 24'h111111 and 24'h222222.
  - Required: read_data={24'h222222, 24'h111111}; read_transparent=2'b01.
- Write during clear and reset mid-sweep:
  - Stimulus: write beats at cycle 10 of the sweep; assert rst at cycle 100.
  - Required: writes dropped (entry reads 0); busy stays 1 until 256 cycles after the second rst release.
- Double buffer (macro defined):
  - Stimulus: commit 24'hFF0000 to entry 5, read entry 5, pulse swap, read entry 5 again.
  - Required: first read returns 0; read issued after the swap edge returns 24'hFF0000; front_bank=1.
